// File: rtl/reorder_buffer_if.sv
// ---------------------------------------------------------------------------
// reorder_buffer_if
//
// Purpose: bundles the issue, writeback, operand-lookup, commit and rollback
// signals of the reorder buffer into one interface so the core and the ROB
// connect through a single port.
//
// Modports:
//   master - the core side (decoder / writeback bus / register file view):
//            drives issue_*, wb_*, q1_pos, q2_pos; observes everything else.
//   slave  - the reorder buffer itself.
//
// Signal summary:
//   rob_full, issue_pos         : allocation status / next tail index
//   issue, issue_rd, issue_is_br, issue_pred_pc, issue_ready, issue_val
//                               : one new instruction per cycle
//   wb_en, wb_pos, wb_val, wb_next_pc
//                               : result writeback bus
//   q1_pos/q2_pos -> q1_rdy/q1_val, q2_rdy/q2_val
//                               : operand lookups for the decoder
//   commit, commit_rd, commit_val, commit_rob_pos
//                               : registered retire port to the register file
//   rollback, rollback_pc       : registered mispredict flush
// ---------------------------------------------------------------------------
interface reorder_buffer_if #(
  parameter int ROB_AW = 4
);

  logic              rob_full;
  logic [ROB_AW-1:0] issue_pos;

  logic              issue;
  logic [4:0]        issue_rd;
  logic              issue_is_br;
  logic [31:0]       issue_pred_pc;
  logic              issue_ready;
  logic [31:0]       issue_val;

  logic              wb_en;
  logic [ROB_AW-1:0] wb_pos;
  logic [31:0]       wb_val;
  logic [31:0]       wb_next_pc;

  logic [ROB_AW-1:0] q1_pos;
  logic [ROB_AW-1:0] q2_pos;
  logic              q1_rdy;
  logic              q2_rdy;
  logic [31:0]       q1_val;
  logic [31:0]       q2_val;

  logic              commit;
  logic [4:0]        commit_rd;
  logic [31:0]       commit_val;
  logic [ROB_AW-1:0] commit_rob_pos;

  logic              rollback;
  logic [31:0]       rollback_pc;

  modport master (
    input  rob_full, issue_pos,
    output issue, issue_rd, issue_is_br, issue_pred_pc, issue_ready, issue_val,
    output wb_en, wb_pos, wb_val, wb_next_pc,
    output q1_pos, q2_pos,
    input  q1_rdy, q2_rdy, q1_val, q2_val,
    input  commit, commit_rd, commit_val, commit_rob_pos,
    input  rollback, rollback_pc
  );

  modport slave (
    output rob_full, issue_pos,
    input  issue, issue_rd, issue_is_br, issue_pred_pc, issue_ready, issue_val,
    input  wb_en, wb_pos, wb_val, wb_next_pc,
    input  q1_pos, q2_pos,
    output q1_rdy, q2_rdy, q1_val, q2_val,
    output commit, commit_rd, commit_val, commit_rob_pos,
    output rollback, rollback_pc
  );

endinterface

// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer
//
// Purpose: circular in-order retirement buffer for the Tomasulo core.
// Allocates one entry per cycle at the tail, captures results from the
// writeback bus, and retires completed head entries in program order,
// driving the register file commit port and the global rollback pulse on a
// branch misprediction.
//
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-low reset, has priority over rdy
//   rdy  - clock enable; when low every register holds its value
//   rob  - reorder_buffer_if.slave (issue / writeback / lookup / commit /
//          rollback signals, see reorder_buffer_if.sv)
//
// Parameters:
//   ROB_SIZE - number of entries (power of two)
//   ROB_AW   - entry index width, log2(ROB_SIZE)
//
// Configuration macro:
//   ROB_FWD_EN - when defined, the q1/q2 lookups forward a same-cycle
//                writeback to a valid entry; when undefined a result becomes
//                visible to the lookups one cycle after its writeback.
// ---------------------------------------------------------------------------
module reorder_buffer #(
  parameter int ROB_SIZE = 16,
  parameter int ROB_AW   = 4
) (
  input logic             clk,
  input logic             rst,
  input logic             rdy,
  reorder_buffer_if.slave rob
);

  localparam logic [ROB_AW:0]   FULL_COUNT = (ROB_AW + 1)'(ROB_SIZE);
  localparam logic [ROB_AW-1:0] POS_ONE    = ROB_AW'(1);

  // Per-entry status bits (reset) and payload (no reset needed: a payload
  // is only ever read while its valid bit is set).
  logic [ROB_SIZE-1:0] ent_valid;
  logic [ROB_SIZE-1:0] ent_ready;
  logic [ROB_SIZE-1:0] ent_is_br;
  logic [4:0]          ent_rd      [ROB_SIZE];
  logic [31:0]         ent_val     [ROB_SIZE];
  logic [31:0]         ent_pred_pc [ROB_SIZE];
  logic [31:0]         ent_next_pc [ROB_SIZE];

  // Circular pointers and occupancy.  count needs one extra bit so that a
  // completely full buffer is distinguishable from an empty one.
  logic [ROB_AW-1:0] head;
  logic [ROB_AW-1:0] tail;
  logic [ROB_AW:0]   count;

  // Registered retire / rollback outputs.
  logic              commit_q;
  logic [4:0]        commit_rd_q;
  logic [31:0]       commit_val_q;
  logic [ROB_AW-1:0] commit_pos_q;
  logic              rollback_q;
  logic [31:0]       rollback_pc_q;

  // Per-cycle decisions.
  logic              issue_accept;
  logic              wb_hit;
  logic              retire;
  logic              mispredict;
  logic [ROB_AW:0]   count_next;

  assign rob.rob_full       = (count == FULL_COUNT);
  assign rob.issue_pos      = tail;
  assign rob.commit         = commit_q;
  assign rob.commit_rd      = commit_rd_q;
  assign rob.commit_val     = commit_val_q;
  assign rob.commit_rob_pos = commit_pos_q;
  assign rob.rollback       = rollback_q;
  assign rob.rollback_pc    = rollback_pc_q;

  // Decide what happens this cycle.  While a rollback pulse is out, the
  // cycle is spent flushing, so issue, writeback and retire are all
  // suppressed.  Fullness is judged on the current count only, so a retire
  // in the same cycle does not free a slot for an issue until next cycle.
  always_comb begin
    issue_accept = rob.issue && !rob.rob_full && !rollback_q;
    wb_hit       = rob.wb_en && ent_valid[rob.wb_pos] && !rollback_q;
    retire       = ent_valid[head] && ent_ready[head] && !rollback_q;
    mispredict   = retire && ent_is_br[head] &&
                   (ent_next_pc[head] != ent_pred_pc[head]);
    count_next   = count + (ROB_AW + 1)'(issue_accept) - (ROB_AW + 1)'(retire);
  end

  // Operand lookups for the decoder.  The stored entry state is the baseline;
  // with forwarding enabled a writeback landing on the looked-up valid entry
  // this very cycle overrides it so the consumer does not lose a cycle.
  always_comb begin
    rob.q1_rdy = ent_valid[rob.q1_pos] && ent_ready[rob.q1_pos];
    rob.q1_val = ent_val[rob.q1_pos];
    rob.q2_rdy = ent_valid[rob.q2_pos] && ent_ready[rob.q2_pos];
    rob.q2_val = ent_val[rob.q2_pos];
`ifdef ROB_FWD_EN
    if (rob.wb_en && (rob.wb_pos == rob.q1_pos) && ent_valid[rob.q1_pos]) begin
      rob.q1_rdy = 1'b1;
      rob.q1_val = rob.wb_val;
    end
    if (rob.wb_en && (rob.wb_pos == rob.q2_pos) && ent_valid[rob.q2_pos]) begin
      rob.q2_rdy = 1'b1;
      rob.q2_val = rob.wb_val;
    end
`else
`endif
  end

  // Control state: pointers, occupancy, status bits and the registered
  // commit / rollback outputs.  Reset wins over rdy; with rdy low everything
  // (including a pending commit or rollback pulse) simply holds.
  //
  // Within a normal cycle the status updates are ordered writeback, retire,
  // issue, so that when issue and writeback target the same index the newly
  // issued entry's ready bit wins.  Retire and issue can never hit the same
  // slot: head == tail only when the buffer is empty (nothing to retire) or
  // full (issue refused).
  always_ff @(posedge clk) begin
    if (!rst) begin
      ent_valid     <= '0;
      ent_ready     <= '0;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      commit_q      <= 1'b0;
      commit_rd_q   <= '0;
      commit_val_q  <= '0;
      commit_pos_q  <= '0;
      rollback_q    <= 1'b0;
      rollback_pc_q <= '0;
    end else if (rdy) begin
      if (rollback_q) begin
        ent_valid  <= '0;
        head       <= '0;
        tail       <= '0;
        count      <= '0;
        commit_q   <= 1'b0;
        rollback_q <= 1'b0;
      end else begin
        if (wb_hit) begin
          ent_ready[rob.wb_pos] <= 1'b1;
        end
        if (retire) begin
          ent_valid[head] <= 1'b0;
          head            <= head + POS_ONE;
          commit_rd_q     <= ent_rd[head];
          commit_val_q    <= ent_val[head];
          commit_pos_q    <= head;
        end
        if (issue_accept) begin
          ent_valid[tail] <= 1'b1;
          ent_ready[tail] <= rob.issue_ready;
          tail            <= tail + POS_ONE;
        end
        count      <= count_next;
        commit_q   <= retire;
        rollback_q <= mispredict;
        if (mispredict) begin
          rollback_pc_q <= ent_next_pc[head];
        end
      end
    end
  end

  // Entry payload.  Writes are gated the same way as the status bits; the
  // issue write comes last so it wins over a same-index writeback.  At issue
  // next_pc is seeded with the predicted PC, so an entry that is complete at
  // issue (never written back) can never be mistaken for a mispredict.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (wb_hit) begin
        ent_val[rob.wb_pos]     <= rob.wb_val;
        ent_next_pc[rob.wb_pos] <= rob.wb_next_pc;
      end
      if (issue_accept) begin
        ent_rd[tail]      <= rob.issue_rd;
        ent_is_br[tail]   <= rob.issue_is_br;
        ent_pred_pc[tail] <= rob.issue_pred_pc;
        ent_next_pc[tail] <= rob.issue_pred_pc;
        ent_val[tail]     <= rob.issue_val;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// ---------------------------------------------------------------------------
// tb_reorder_buffer
//
// Purpose: self-checking bench for reorder_buffer.  A vector table drives
// cycle-by-cycle issue / writeback / lookup traffic and checks the
// combinational status outputs; hand-written sequences cover full buffer,
// mispredict flush, mid-stream reset and clock-enable hold.  Every issued
// instruction expected to retire is pushed on a scoreboard queue, and a
// monitor pops and compares on each commit pulse.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reorder_buffer;

  localparam int ROB_SIZE = 16;
  localparam int ROB_AW   = 4;
`ifdef ROB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;

  reorder_buffer_if #(.ROB_AW(ROB_AW)) bus ();

  reorder_buffer #(
    .ROB_SIZE(ROB_SIZE),
    .ROB_AW  (ROB_AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .rob(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
    logic [3:0]  pos;
  } commit_t;

  typedef struct {
    logic        issue;
    logic [4:0]  rd;
    logic        ready;
    logic [31:0] val;
    logic        wb_en;
    logic [3:0]  wb_pos;
    logic [31:0] wb_val;
    logic [3:0]  q1_pos;
    logic [3:0]  q2_pos;
    logic [31:0] commit_val;
    logic        exp_full;
    logic [3:0]  exp_pos;
    logic        exp_q1_rdy;
    logic [31:0] exp_q1_val;
    logic        exp_q2_rdy;
    logic [31:0] exp_q2_val;
  } vec_t;

  commit_t sb[$];
  commit_t mon_exp;
  vec_t    vecs[11];
  int      compared   = 0;
  int      mismatched = 0;
  logic    mon_live;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.issue         = 1'b0;
    bus.issue_rd      = '0;
    bus.issue_is_br   = 1'b0;
    bus.issue_pred_pc = '0;
    bus.issue_ready   = 1'b0;
    bus.issue_val     = '0;
    bus.wb_en         = 1'b0;
    bus.wb_pos        = '0;
    bus.wb_val        = '0;
    bus.wb_next_pc    = '0;
    bus.q1_pos        = '0;
    bus.q2_pos        = '0;
    rdy               = 1'b1;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    idle_inputs();
    tick();
    rst = 1'b1;
    sb.delete();
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [31:0] val,
                          input logic [3:0] pos);
    commit_t e;
    e.rd  = rd;
    e.val = val;
    e.pos = pos;
    sb.push_back(e);
  endtask

  task automatic drive_issue(input logic [4:0] rd, input logic ready,
                             input logic [31:0] val, input logic is_br,
                             input logic [31:0] pred);
    bus.issue         = 1'b1;
    bus.issue_rd      = rd;
    bus.issue_ready   = ready;
    bus.issue_val     = val;
    bus.issue_is_br   = is_br;
    bus.issue_pred_pc = pred;
  endtask

  task automatic drive_wb(input logic [3:0] pos, input logic [31:0] val,
                          input logic [31:0] next_pc);
    bus.wb_en      = 1'b1;
    bus.wb_pos     = pos;
    bus.wb_val     = val;
    bus.wb_next_pc = next_pc;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.issue         = v.issue;
    bus.issue_rd      = v.rd;
    bus.issue_ready   = v.ready;
    bus.issue_val     = v.val;
    bus.issue_is_br   = 1'b0;
    bus.issue_pred_pc = '0;
    bus.wb_en         = v.wb_en;
    bus.wb_pos        = v.wb_pos;
    bus.wb_val        = v.wb_val;
    bus.wb_next_pc    = '0;
    bus.q1_pos        = v.q1_pos;
    bus.q2_pos        = v.q2_pos;
    #1;
  endtask

  // Commit monitor: a new commit pulse appears only after an edge where the
  // DUT was out of reset and enabled; each one must match the oldest
  // outstanding scoreboard entry.
  always @(posedge clk) begin
    mon_live = rst && rdy;
    #1;
    if (mon_live && bus.commit) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_commit: got rd=%0d val=0x%0h pos=%0d, expected no commit",
                 bus.commit_rd, bus.commit_val, bus.commit_rob_pos);
      end else begin
        mon_exp = sb.pop_front();
        checkOutput("commit_rd",  32'(bus.commit_rd),      32'(mon_exp.rd));
        checkOutput("commit_val", bus.commit_val,          mon_exp.val);
        checkOutput("commit_pos", 32'(bus.commit_rob_pos), 32'(mon_exp.pos));
      end
    end
  end

  task automatic fill_vectors();
    //          iss rd     rdy  val           wb   pos   wbval         q1    q2    cval          full pos   q1r   q1v           q2r   q2v
    vecs[0]  = '{1'b1, 5'd5, 1'b1, 32'h1234, 1'b0, 4'd0, 32'h0,  4'd0, 4'd1, 32'h1234, 1'b0, 4'd0, 1'b0, 32'h0,    1'b0, 32'h0};
    vecs[1]  = '{1'b1, 5'd6, 1'b0, 32'h0,    1'b0, 4'd0, 32'h0,  4'd0, 4'd1, 32'hAB,   1'b0, 4'd1, 1'b1, 32'h1234, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 5'd0, 1'b0, 32'h0,    1'b1, 4'd1, 32'hAB, 4'd1, 4'd0, 32'h0,    1'b0, 4'd2, FWD,  32'hAB,   1'b0, 32'h0};
    vecs[3]  = '{1'b1, 5'd7, 1'b0, 32'h0,    1'b0, 4'd0, 32'h0,  4'd1, 4'd2, 32'h22,   1'b0, 4'd2, 1'b1, 32'hAB,   1'b0, 32'h0};
    vecs[4]  = '{1'b1, 5'd8, 1'b0, 32'h0,    1'b0, 4'd0, 32'h0,  4'd2, 4'd1, 32'h33,   1'b0, 4'd3, 1'b0, 32'h0,    1'b0, 32'h0};
    vecs[5]  = '{1'b0, 5'd0, 1'b0, 32'h0,    1'b1, 4'd3, 32'h33, 4'd3, 4'd2, 32'h0,    1'b0, 4'd4, FWD,  32'h33,   1'b0, 32'h0};
    vecs[6]  = '{1'b0, 5'd0, 1'b0, 32'h0,    1'b1, 4'd2, 32'h22, 4'd3, 4'd2, 32'h0,    1'b0, 4'd4, 1'b1, 32'h33,   FWD,  32'h22};
    vecs[7]  = '{1'b0, 5'd0, 1'b0, 32'h0,    1'b0, 4'd0, 32'h0,  4'd2, 4'd3, 32'h0,    1'b0, 4'd4, 1'b1, 32'h22,   1'b1, 32'h33};
    vecs[8]  = '{1'b0, 5'd0, 1'b0, 32'h0,    1'b0, 4'd0, 32'h0,  4'd2, 4'd3, 32'h0,    1'b0, 4'd4, 1'b0, 32'h0,    1'b1, 32'h33};
    vecs[9]  = '{1'b0, 5'd0, 1'b0, 32'h0,    1'b1, 4'd5, 32'h55, 4'd5, 4'd3, 32'h0,    1'b0, 4'd4, 1'b0, 32'h0,    1'b0, 32'h0};
    vecs[10] = '{1'b0, 5'd0, 1'b0, 32'h0,    1'b0, 4'd0, 32'h0,  4'd5, 4'd4, 32'h0,    1'b0, 4'd4, 1'b0, 32'h0,    1'b0, 32'h0};
  endtask

  // Table-driven traffic: in-order retire, out-of-order writeback, lookups
  // with and without same-cycle forwarding, writeback to an invalid entry.
  task automatic run_table();
    reset_dut();
    fill_vectors();
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      checkOutput("tbl_full",   32'(bus.rob_full),  32'(vecs[i].exp_full));
      checkOutput("tbl_pos",    32'(bus.issue_pos), 32'(vecs[i].exp_pos));
      checkOutput("tbl_q1_rdy", 32'(bus.q1_rdy),    32'(vecs[i].exp_q1_rdy));
      checkOutput("tbl_q2_rdy", 32'(bus.q2_rdy),    32'(vecs[i].exp_q2_rdy));
      if (vecs[i].exp_q1_rdy) checkOutput("tbl_q1_val", bus.q1_val, vecs[i].exp_q1_val);
      if (vecs[i].exp_q2_rdy) checkOutput("tbl_q2_val", bus.q2_val, vecs[i].exp_q2_val);
      if (vecs[i].issue) push_exp(vecs[i].rd, vecs[i].commit_val, vecs[i].exp_pos);
      tick();
    end
    idle_inputs();
    repeat (2) tick();
    checkOutput("tbl_drained", 32'(sb.size()), 32'd0);
  endtask

  // Fill all sixteen slots, refuse further issues (also on the retire
  // cycle), then release by writing back in order with wraparound.
  task automatic run_full();
    reset_dut();
    for (int i = 0; i < ROB_SIZE; i++) begin
      drive_issue(5'(i + 1), 1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      checkOutput("fill_pos", 32'(bus.issue_pos), 32'(i));
      push_exp(5'(i + 1), 32'h1000 + 32'(i), 4'(i));
      tick();
    end
    drive_issue(5'd31, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0);
    #1;
    checkOutput("full_flag", 32'(bus.rob_full),  32'd1);
    checkOutput("full_pos",  32'(bus.issue_pos), 32'd0);
    tick();
    checkOutput("full_ignore_pos", 32'(bus.issue_pos), 32'd0);
    drive_wb(4'd0, 32'h1000, 32'h0);
    tick();
    checkOutput("full_after_wb", 32'(bus.rob_full), 32'd1);
    bus.wb_en = 1'b0;
    tick();
    checkOutput("full_released",   32'(bus.rob_full),  32'd0);
    checkOutput("full_retire_pos", 32'(bus.issue_pos), 32'd0);
    bus.issue = 1'b0;
    for (int i = 1; i < ROB_SIZE; i++) begin
      drive_wb(4'(i), 32'h1000 + 32'(i), 32'h0);
      tick();
    end
    bus.wb_en = 1'b0;
    repeat (3) tick();
    checkOutput("full_drained",   32'(sb.size()),    32'd0);
    checkOutput("full_empty_pos", 32'(bus.issue_pos), 32'd0);
  endtask

  // Mispredicted branch at head: commit plus rollback on the same edge, flush
  // on the next, then a correctly predicted branch that must not roll back.
  task automatic run_mispredict();
    reset_dut();
    drive_issue(5'd1, 1'b0, 32'h0, 1'b1, 32'h100);
    push_exp(5'd1, 32'h5A, 4'd0);
    tick();
    drive_issue(5'd9, 1'b1, 32'h99, 1'b0, 32'h0);
    tick();
    bus.issue = 1'b0;
    drive_wb(4'd0, 32'h5A, 32'h200);
    tick();
    bus.wb_en = 1'b0;
    tick();
    checkOutput("mp_commit",      32'(bus.commit),   32'd1);
    checkOutput("mp_rollback",    32'(bus.rollback), 32'd1);
    checkOutput("mp_rollback_pc", bus.rollback_pc,   32'h200);
    drive_issue(5'd12, 1'b1, 32'hEE, 1'b0, 32'h0);
    drive_wb(4'd1, 32'h11, 32'h0);
    tick();
    checkOutput("flush_rollback", 32'(bus.rollback),  32'd0);
    checkOutput("flush_commit",   32'(bus.commit),    32'd0);
    checkOutput("flush_pos",      32'(bus.issue_pos), 32'd0);
    checkOutput("flush_full",     32'(bus.rob_full),  32'd0);
    bus.wb_en = 1'b0;
    drive_issue(5'd3, 1'b1, 32'h77, 1'b0, 32'h0);
    push_exp(5'd3, 32'h77, 4'd0);
    tick();
    drive_issue(5'd2, 1'b0, 32'h0, 1'b1, 32'h300);
    push_exp(5'd2, 32'hB0, 4'd1);
    tick();
    bus.issue = 1'b0;
    drive_wb(4'd1, 32'hB0, 32'h300);
    tick();
    bus.wb_en = 1'b0;
    tick();
    checkOutput("good_br_commit",   32'(bus.commit),   32'd1);
    checkOutput("good_br_rollback", 32'(bus.rollback), 32'd0);
    tick();
    checkOutput("mp_drained", 32'(sb.size()), 32'd0);
  endtask

  // Reset asserted while five entries are outstanding and the head is ready
  // to commit; every registered output must clear and nothing may retire.
  task automatic run_mid_reset();
    for (int i = 0; i < 5; i++) begin
      drive_issue(5'(20 + i), 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
    end
    bus.issue = 1'b0;
    drive_wb(4'd2, 32'h5, 32'h0);
    tick();
    bus.wb_en = 1'b0;
    rst = 1'b0;
    tick();
    checkOutput("rst_commit",      32'(bus.commit),         32'd0);
    checkOutput("rst_commit_rd",   32'(bus.commit_rd),      32'd0);
    checkOutput("rst_commit_val",  bus.commit_val,          32'd0);
    checkOutput("rst_commit_pos",  32'(bus.commit_rob_pos), 32'd0);
    checkOutput("rst_rollback",    32'(bus.rollback),       32'd0);
    checkOutput("rst_rollback_pc", bus.rollback_pc,         32'd0);
    checkOutput("rst_full",        32'(bus.rob_full),       32'd0);
    checkOutput("rst_pos",         32'(bus.issue_pos),      32'd0);
    rst = 1'b1;
    repeat (3) tick();
    checkOutput("rst_no_residue", 32'(bus.issue_pos), 32'd0);
  endtask

  // Clock enable low: commit pulse and tail hold, issue is ignored.
  task automatic run_rdy_hold();
    drive_issue(5'd4, 1'b1, 32'h4444, 1'b0, 32'h0);
    push_exp(5'd4, 32'h4444, 4'd0);
    tick();
    bus.issue = 1'b0;
    tick();
    rdy = 1'b0;
    drive_issue(5'd9, 1'b1, 32'h9, 1'b0, 32'h0);
    tick();
    checkOutput("rdy_hold_commit", 32'(bus.commit),    32'd1);
    checkOutput("rdy_hold_val",    bus.commit_val,     32'h4444);
    checkOutput("rdy_hold_pos",    32'(bus.issue_pos), 32'd1);
    rdy = 1'b1;
    bus.issue = 1'b0;
    tick();
    checkOutput("rdy_pulse_end", 32'(bus.commit), 32'd0);
    repeat (2) tick();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    repeat (2) tick();
    checkOutput("reset_commit",      32'(bus.commit),         32'd0);
    checkOutput("reset_commit_rd",   32'(bus.commit_rd),      32'd0);
    checkOutput("reset_commit_val",  bus.commit_val,          32'd0);
    checkOutput("reset_commit_pos",  32'(bus.commit_rob_pos), 32'd0);
    checkOutput("reset_rollback",    32'(bus.rollback),       32'd0);
    checkOutput("reset_rollback_pc", bus.rollback_pc,         32'd0);
    checkOutput("reset_full",        32'(bus.rob_full),       32'd0);
    checkOutput("reset_pos",         32'(bus.issue_pos),      32'd0);
    rst = 1'b1;

    $display("[TB] vector table");
    run_table();
    $display("[TB] full buffer");
    run_full();
    $display("[TB] mispredict and flush");
    run_mispredict();
    $display("[TB] mid-stream reset");
    run_mid_reset();
    $display("[TB] clock enable hold");
    run_rdy_hold();

    checkOutput("final_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
